mc_proc_controller: RTL and testbench

- Multi-cycle successor to the single-cycle processor controller.
- Holds the latched instruction (IR) and a state machine (FETCH/DECODE/EXEC/MEM/WB/TRAP).
- Emits per-state datapath strobes and mux selects, so the processor can share one ALU and use memories that take variable time to answer.
- Widths are parametrised; memory ready handshakes and illegal-opcode trapping are new in this generation.

---
 rtl/mc_proc_controller.sv | 138 +++++++++++++
 tb/tb_mc_proc_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_proc_controller.sv
// mc_proc_controller: multi-cycle processor controller with IR, FETCH/DECODE/EXEC/MEM/WB/TRAP FSM and datapath strobes
//   in : clk, reset (sync, active-high), inst, imem_ready, dmem_ready, cond_flag
//   out: imem_req, ir_wrt_en, rd, rs1, rs2, imm, alu_op, alu_in2_sel, pc_sel, rf_wrt_data_sel,
//        rf_wrt_en, mem_rd_en, mem_wrt_en, pc_wrt_en, instret, halted, state
module mc_proc_controller #(
  parameter int INST_BIT_WIDTH      = 32,
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int ALU_OP_WIDTH        = 5,
  parameter int IMM_WIDTH           = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [INST_BIT_WIDTH-1:0]      inst,
  input  logic                           imem_ready,
  input  logic                           dmem_ready,
  input  logic                           cond_flag,
  output logic                           imem_req,
  output logic                           ir_wrt_en,
  output logic [REG_INDEX_BIT_WIDTH-1:0] rd,
  output logic [REG_INDEX_BIT_WIDTH-1:0] rs1,
  output logic [REG_INDEX_BIT_WIDTH-1:0] rs2,
  output logic [IMM_WIDTH-1:0]           imm,
  output logic [ALU_OP_WIDTH-1:0]        alu_op,
  output logic [1:0]                     alu_in2_sel,
  output logic [1:0]                     pc_sel,
  output logic [1:0]                     rf_wrt_data_sel,
  output logic                           rf_wrt_en,
  output logic                           mem_rd_en,
  output logic                           mem_wrt_en,
  output logic                           pc_wrt_en,
  output logic                           instret,
  output logic                           halted,
  output logic [2:0]                     state
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  logic [2:0]                state_q, state_d;
  logic [INST_BIT_WIDTH-1:0] ir_q, ir_d;
  logic                      halted_q, halted_d;

  logic [3:0] op, fn;
  logic       is_alu, is_cmp, is_br, is_lw, is_sw, is_jal, is_imm, legal;

  assign op     = ir_q[31:28];
  assign fn     = ir_q[27:24];
  assign is_alu = (op == 4'b1100) || (op == 4'b0100);
  assign is_cmp = (op == 4'b1101) || (op == 4'b0101);
  assign is_br  = op == 4'b0010;
  assign is_lw  = op == 4'b0111;
  assign is_sw  = op == 4'b0011;
  assign is_jal = op == 4'b0110;
  assign is_imm = (op == 4'b0100) || (op == 4'b0101);
  assign legal  = is_alu | is_cmp | is_br | is_lw | is_sw | is_jal;

  assign rd          = REG_INDEX_BIT_WIDTH'(ir_q[23:20]);
  assign rs1         = REG_INDEX_BIT_WIDTH'(is_br ? ir_q[23:20] : ir_q[19:16]);
  assign rs2         = REG_INDEX_BIT_WIDTH'(is_sw ? ir_q[23:20] : is_br ? ir_q[19:16] : ir_q[15:12]);
  assign imm         = ir_q[IMM_WIDTH-1:0];
  assign alu_op      = (is_alu | is_cmp | is_br) ? ALU_OP_WIDTH'({is_cmp | is_br, fn}) : '0;
  assign alu_in2_sel = (is_imm | is_lw | is_sw) ? 2'b01 : is_jal ? 2'b10 : 2'b00;
  assign halted      = halted_q;
  assign state       = state_q;

  always_comb begin
    state_d         = state_q;
    imem_req        = 1'b0;
    ir_wrt_en       = 1'b0;
    rf_wrt_en       = 1'b0;
    mem_rd_en       = 1'b0;
    mem_wrt_en      = 1'b0;
    pc_wrt_en       = 1'b0;
    instret         = 1'b0;
    pc_sel          = 2'b00;
    rf_wrt_data_sel = 2'b00;
    case (state_q)
      S_FETCH: begin
        imem_req  = 1'b1;
        ir_wrt_en = imem_ready;
        state_d   = imem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        pc_wrt_en = is_br;
        instret   = is_br;
        pc_sel    = (is_br && cond_flag) ? 2'b01 : 2'b00;
        state_d   = is_br ? S_FETCH : (is_lw | is_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_rd_en  = is_lw;
        mem_wrt_en = is_sw;
        pc_wrt_en  = dmem_ready & is_sw;
        instret    = dmem_ready & is_sw;
        state_d    = !dmem_ready ? S_MEM : is_lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        rf_wrt_en       = 1'b1;
        pc_wrt_en       = 1'b1;
        instret         = 1'b1;
        rf_wrt_data_sel = is_lw ? 2'b01 : is_jal ? 2'b10 : 2'b00;
        pc_sel          = is_jal ? 2'b10 : 2'b00;
        state_d         = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    // A reset cycle aborts the instruction: no PC/RF/memory side effect may escape
    if (reset) begin
      imem_req        = 1'b0;
      ir_wrt_en       = 1'b0;
      rf_wrt_en       = 1'b0;
      mem_rd_en       = 1'b0;
      mem_wrt_en      = 1'b0;
      pc_wrt_en       = 1'b0;
      instret         = 1'b0;
      pc_sel          = 2'b00;
      rf_wrt_data_sel = 2'b00;
    end
    ir_d     = ir_wrt_en ? inst : ir_q;
    halted_d = halted_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end
endmodule

// File: tb/tb_mc_proc_controller.sv
// tb_mc_proc_controller: table vectors, hand sequences and random instruction streams against a per-instruction phase model
module tb_mc_proc_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst = '0;
  logic        imem_ready = 1'b0, dmem_ready = 1'b0, cond_flag = 1'b0;
  logic        imem_req, ir_wrt_en, rf_wrt_en, mem_rd_en, mem_wrt_en, pc_wrt_en, instret, halted;
  logic [3:0]  rd, rs1, rs2;
  logic [15:0] imm;
  logic [4:0]  alu_op;
  logic [1:0]  alu_in2_sel, pc_sel, rf_wrt_data_sel;
  logic [2:0]  state;
  logic [14:0] act_v;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0]  rd, rs1, rs2;
    logic [15:0] imm;
    logic [4:0]  aop;
    logic [1:0]  in2;
  } dec_t;

  typedef struct {
    logic [31:0] inst;
    logic        cond;
    dec_t        d;
    int          lat;
  } vec_t;

  mc_proc_controller dut (
    .clk(clk), .reset(reset), .inst(inst), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .cond_flag(cond_flag), .imem_req(imem_req), .ir_wrt_en(ir_wrt_en), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .alu_op(alu_op), .alu_in2_sel(alu_in2_sel), .pc_sel(pc_sel),
    .rf_wrt_data_sel(rf_wrt_data_sel), .rf_wrt_en(rf_wrt_en), .mem_rd_en(mem_rd_en),
    .mem_wrt_en(mem_wrt_en), .pc_wrt_en(pc_wrt_en), .instret(instret), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  assign act_v = {state, imem_req, ir_wrt_en, rf_wrt_en, mem_rd_en, mem_wrt_en, pc_wrt_en, instret,
                  halted, pc_sel, rf_wrt_data_sel};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [14:0] ev(input logic [2:0] st, input logic imr, irw, rfw, mrd, mwr, pcw, ir, h,
                                     input logic [1:0] ps, ws);
    return {st, imr, irw, rfw, mrd, mwr, pcw, ir, h, ps, ws};
  endfunction

  task automatic cyc(input logic [14:0] exp, input string nm);
    @(negedge clk);
    chk(nm, 32'(act_v), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  function automatic dec_t ref_dec(input logic [31:0] i);
    dec_t d;
    logic [3:0] o;
    o     = i[31:28];
    d.rd  = i[23:20];
    d.imm = i[15:0];
    d.rs1 = (o == 4'h2) ? i[23:20] : i[19:16];
    d.rs2 = (o == 4'h3) ? i[23:20] : (o == 4'h2) ? i[19:16] : i[15:12];
    d.aop = (o inside {4'hC, 4'h4}) ? {1'b0, i[27:24]} : (o inside {4'hD, 4'h5, 4'h2}) ? {1'b1, i[27:24]} : 5'd0;
    d.in2 = (o inside {4'h4, 4'h5, 4'h7, 4'h3}) ? 2'd1 : (o == 4'h6) ? 2'd2 : 2'd0;
    return d;
  endfunction

  task automatic check_dec(input dec_t e);
    chk("rd", 32'(rd), 32'(e.rd));
    chk("rs1", 32'(rs1), 32'(e.rs1));
    chk("rs2", 32'(rs2), 32'(e.rs2));
    chk("imm", 32'(imm), 32'(e.imm));
    chk("alu_op", 32'(alu_op), 32'(e.aop));
    chk("alu_in2_sel", 32'(alu_in2_sel), 32'(e.in2));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_reset");
  endtask

  // Walks one instruction through its expected phases; lat = cycles to retire, -1 when it traps
  task automatic run_instr(input logic [31:0] i, input int fw, input int dw, input logic cond,
                           input dec_t ed, output int lat);
    logic [3:0] o;
    bit lw, sw, br, jal, legal;
    o = i[31:28];
    lw = o == 4'h7;
    sw = o == 4'h3;
    br = o == 4'h2;
    jal = o == 4'h6;
    legal = o inside {4'hC, 4'h4, 4'hD, 4'h5, 4'h2, 4'h7, 4'h3, 4'h6};
    lat = 0;
    dmem_ready = 1'($urandom);
    cond_flag = 1'($urandom);
    for (int k = 0; k < fw; k++) begin
      imem_ready = 1'b0;
      inst = $urandom;
      cyc(ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "fetch_wait");
      lat++;
    end
    inst = i;
    imem_ready = 1'b1;
    cyc(ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), "fetch");
    lat++;
    inst = $urandom;
    imem_ready = 1'($urandom);
    check_dec(ed);
    cyc(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "decode");
    lat++;
    if (!legal) begin
      for (int k = 0; k < 3; k++) cyc(ev(7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "trap");
      lat = -1;
      return;
    end
    cond_flag = cond;
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    if (br) begin
      cyc(ev(2, 0, 0, 0, 0, 0, 1, 1, 0, cond ? 2'd1 : 2'd0, 0), "exec_br");
      lat++;
      return;
    end
    cyc(ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "exec");
    lat++;
    cond_flag = 1'($urandom);
    if (lw || sw) begin
      for (int k = 0; k < dw; k++) begin
        dmem_ready = 1'b0;
        cyc(ev(3, 0, 0, 0, lw, sw, 0, 0, 0, 0, 0), "mem_wait");
        lat++;
      end
      dmem_ready = 1'b1;
      cyc(ev(3, 0, 0, 0, lw, sw, sw, sw, 0, 0, 0), "mem_done");
      lat++;
      if (sw) return;
    end
    dmem_ready = 1'($urandom);
    cyc(ev(4, 0, 0, 1, 0, 0, 1, 1, 0, jal ? 2'd2 : 2'd0, lw ? 2'd1 : jal ? 2'd2 : 2'd0), "wb");
    lat++;
  endtask

  vec_t       tbl[8];
  logic [3:0] legal_ops[8];

  initial begin
    int lat, fw, dw, exp_lat;
    logic [3:0] o;
    logic [31:0] ri;
    logic c;
    tbl[0] = '{32'hC7120000, 1'b0, '{4'h1, 4'h2, 4'h0, 16'h0000, 5'h07, 2'd0}, 4};
    tbl[1] = '{32'h4A35BEEF, 1'b1, '{4'h3, 4'h5, 4'hB, 16'hBEEF, 5'h0A, 2'd1}, 4};
    tbl[2] = '{32'hD3789000, 1'b0, '{4'h7, 4'h8, 4'h9, 16'h9000, 5'h13, 2'd0}, 4};
    tbl[3] = '{32'h5F12FFFF, 1'b1, '{4'h1, 4'h2, 4'hF, 16'hFFFF, 5'h1F, 2'd1}, 4};
    tbl[4] = '{32'h70340008, 1'b0, '{4'h3, 4'h4, 4'h0, 16'h0008, 5'h00, 2'd1}, 5};
    tbl[5] = '{32'h30120004, 1'b1, '{4'h1, 4'h2, 4'h1, 16'h0004, 5'h00, 2'd1}, 4};
    tbl[6] = '{32'h26540010, 1'b1, '{4'h5, 4'h5, 4'h4, 16'h0010, 5'h16, 2'd0}, 3};
    tbl[7] = '{32'h69AB1234, 1'b0, '{4'hA, 4'hB, 4'h1, 16'h1234, 5'h00, 2'd2}, 4};
    legal_ops = '{4'hC, 4'h4, 4'hD, 4'h5, 4'h2, 4'h7, 4'h3, 4'h6};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_dec('{4'h0, 4'h0, 4'h0, 16'h0000, 5'h00, 2'd0});
    cyc(ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "reset_state");

    for (int k = 0; k < 8; k++) begin
      run_instr(tbl[k].inst, 0, 0, tbl[k].cond, tbl[k].d, lat);
      chk("table_latency", 32'(lat), 32'(tbl[k].lat));
    end

    run_instr(32'h70340008, 0, 3, 1'b0, tbl[4].d, lat);
    chk("lw_wait3_latency", 32'(lat), 32'd8);
    run_instr(32'h26540010, 0, 0, 1'b1, tbl[6].d, lat);
    chk("br_taken_latency", 32'(lat), 32'd3);
    run_instr(32'h26540010, 1, 0, 1'b0, tbl[6].d, lat);
    chk("br_not_taken_latency", 32'(lat), 32'd4);
    run_instr(32'h30120004, 0, 2, 1'b0, tbl[5].d, lat);
    chk("sw_wait2_latency", 32'(lat), 32'd6);

    run_instr(32'hF0000000, 0, 0, 1'b0, ref_dec(32'hF0000000), lat);
    chk("illegal_traps", 32'(lat), 32'hFFFFFFFF);
    for (int k = 0; k < 10; k++) begin
      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      cond_flag = 1'($urandom);
      inst = $urandom;
      cyc(ev(7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "trap_sticky");
    end
    do_reset();
    run_instr(32'hC7120000, 0, 0, 1'b0, tbl[0].d, lat);
    chk("restart_after_trap", 32'(lat), 32'd4);

    inst = 32'h30120004;
    imem_ready = 1'b1;
    cyc(ev(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), "abort_fetch");
    imem_ready = 1'b0;
    cyc(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "abort_decode");
    dmem_ready = 1'b0;
    cyc(ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "abort_exec");
    cyc(ev(3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "abort_mem_wait");
    reset = 1'b1;
    dmem_ready = 1'b1;
    cyc(ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "abort_reset_cycle");
    reset = 1'b0;
    cyc(ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "abort_after_reset");

    for (int n = 0; n < 200; n++) begin
      o = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 7)];
      ri = {o, 28'($urandom)};
      fw = $urandom_range(0, 2);
      dw = $urandom_range(0, 3);
      c = 1'($urandom);
      exp_lat = !(o inside {4'hC, 4'h4, 4'hD, 4'h5, 4'h2, 4'h7, 4'h3, 4'h6}) ? -1 :
                ((o == 4'h2) ? 3 : (o == 4'h7) ? 5 : 4) + fw + ((o == 4'h7 || o == 4'h3) ? dw : 0);
      run_instr(ri, fw, dw, c, ref_dec(ri), lat);
      chk("rand_latency", 32'(lat), 32'(exp_lat));
      if (lat < 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
